// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display: active-low segment
// patterns, adjustment-field codes and the scan-slot enumeration.
package disp_pkg;

  localparam int unsigned N_SLOTS = 6;

  // Segment patterns ordered {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Field currently under adjustment
  localparam logic [3:0] FIELD_HH = 4'd1;
  localparam logic [3:0] FIELD_MM = 4'd2;
  localparam logic [3:0] FIELD_SS = 4'd3;

  // Scan slot; the value is also the anode bit that slot drives
  typedef enum logic [2:0] {
    SLOT_SS0 = 3'd0,
    SLOT_SS1 = 3'd1,
    SLOT_MM0 = 3'd2,
    SLOT_MM1 = 3'd3,
    SLOT_HH0 = 3'd4,
    SLOT_HH1 = 3'd5
  } slot_e;

  function automatic slot_e next_slot(input slot_e s);
    return (s == SLOT_HH1) ? SLOT_SS0 : slot_e'(s + 3'd1);
  endfunction

  function automatic logic [7:0] slot_anode(input slot_e s);
    return ~(8'b0000_0001 << s);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module bcd_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Digit lookup
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_mux_7seg.sv
// Six-digit HH.MM.SS time-multiplexed driver for an 8-anode common-anode
// 7-segment display with anti-ghost blanking at each slot start.
// Optional feature macro DISP_BLINK_EN: blinks the field selected by en_count.
module display_mux_7seg
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned BLINK_TICKS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] en_count,
  input  logic [3:0] hh1,
  input  logic [3:0] hh0,
  input  logic [3:0] mm1,
  input  logic [3:0] mm0,
  input  logic [3:0] ss1,
  input  logic [3:0] ss0,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYC);

  logic [PRE_W-1:0] r_pre;
  slot_e            r_idx;
  logic             w_tick;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg;
  logic             w_blank;
  logic [7:0]       w_an;
  logic             w_dp;

  assign w_tick = (r_pre == PRE_LAST);

  // Prescaler and slot scan
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
      r_idx <= SLOT_SS0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_idx <= next_slot(r_idx);
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned BCNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_TICKS - 1);

  logic [BCNT_W-1:0] r_bcnt;
  logic              r_phase;

  // Blink half-period counter; phase=1 means the selected field is visible
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (w_tick) begin
      if (r_bcnt == BCNT_LAST) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  // Hide the slots of the selected field during the dark phase
  always_comb begin
    w_blank = 1'b0;
    if (!r_phase) begin
      case (en_count)
        FIELD_HH: w_blank = (r_idx == SLOT_HH0) || (r_idx == SLOT_HH1);
        FIELD_MM: w_blank = (r_idx == SLOT_MM0) || (r_idx == SLOT_MM1);
        FIELD_SS: w_blank = (r_idx == SLOT_SS0) || (r_idx == SLOT_SS1);
        default:  w_blank = 1'b0;
      endcase
    end
  end
`else
  logic w_unused_cfg;

  assign w_blank      = 1'b0;
  assign w_unused_cfg = (^en_count) ^ (BLINK_TICKS == 0);
`endif

  // Digit select for the active slot
  always_comb begin
    w_digit = ss0;
    case (r_idx)
      SLOT_SS0: w_digit = ss0;
      SLOT_SS1: w_digit = ss1;
      SLOT_MM0: w_digit = mm0;
      SLOT_MM1: w_digit = mm1;
      SLOT_HH0: w_digit = hh0;
      SLOT_HH1: w_digit = hh1;
      default:  w_digit = ss0;
    endcase
  end

  bcd_to_7seg u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  // Next anode / decimal-point values
  always_comb begin
    w_an = '1;
    if ((r_pre >= PRE_BLANK) && !w_blank) begin
      w_an = slot_anode(r_idx);
    end
    w_dp = !((r_idx == SLOT_MM0) || (r_idx == SLOT_HH0));
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= w_an;
      seg <= w_seg;
      dp  <= w_dp;
    end
  end

endmodule

// File: doc/display_mux_7seg.md
# display_mux_7seg

Downstream consumer of the two-digit BCD counters: takes six BCD digits (hours, minutes, seconds) and drives an 8-anode, active-low, common-anode 7-segment display by time multiplexing. Blinks the field currently selected for adjustment (`en_count`), blanks anodes between digit changes to suppress ghosting and maps non-BCD codes to a dash. Sits between the time counters and the board pins.

## Interface
- `REFRESH_DIV`, 100000: clk cycles per digit slot (1 kHz slot rate at 100 MHz); ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, 16: cycles at the start of each slot with all anodes off.
- `BLINK_TICKS`, 256: refresh ticks per blink half-period (~2 Hz toggle at defaults); ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous reset, active-low (asserted at 0).
- `en_count`  in  4  field under adjustment: 1 hours, 2 minutes, 3 seconds, any other value none.
- `hh1`, `hh0`, `mm1`, `mm0`, `ss1`, `ss0`  in  4 each  BCD digits, tens/units.
- `an`  out  8  anode enables, active-low; `an[0]` is rightmost.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- Prescaler `pre` counts 0..`REFRESH_DIV`-1 and wraps; refresh tick = (`pre` == `REFRESH_DIV`-1).
- Slot index `idx` 0..5 advances on each tick and wraps 5→0. Mapping: 0 `ss0`/`an[0]`, 1 `ss1`, 2 `mm0`, 3 `mm1`, 4 `hh0`, 5 `hh1`/`an[5]`. `an[7:6]` are always 1.
- Decode: 0–9 give standard patterns (0 → 7'b1000000, 8 → 7'b0000000); 10–15 give a dash, 7'b0111111.
- `dp` = 0 in slots 2 and 4 (HH.MM.SS separators), otherwise 1.
- Blink: counter `bcnt` counts ticks; on reaching `BLINK_TICKS`-1 it clears and `phase` toggles. `phase`=1 means visible.
- Blank: the anode is held at 1 when `phase`=0 and the slot belongs to the selected field (1 → idx 4,5; 2 → idx 2,3; 3 → idx 0,1). With `en_count` outside 1..3, no slot is blinked.
- Anti-ghost: `an` = 8'hFF while `pre` < `BLANK_CYC`; `seg`/`dp` still update.
- Inputs are used without synchronisation (same clock domain). A digit change is visible the next cycle it is in slot.

## Timing
- `an`, `seg` and `dp` are registered and recomputed every clk from the current `idx`, `pre`, `phase` and inputs, giving 1-cycle latency.
- Reset (async assert, release on clk): `pre`=0, `idx`=0, `bcnt`=0, `phase`=1, `an`=8'hFF, `seg`=7'h7F, `dp`=1.
- Reset asserted mid-slot: outputs go to reset values immediately, without waiting for clk. After release the scan restarts at slot 0 with `phase`=1.
- A tick at idx 5 and `bcnt`=`BLINK_TICKS`-1 on the same edge: `idx`→0 and `phase` toggles together.
- An `en_count` change takes effect on the next registered output; `bcnt`/`phase` are not reset, so blink continues in phase.
- Full scan period is 6·`REFRESH_DIV` cycles; each lit slot is on for `REFRESH_DIV`-`BLANK_CYC` cycles.

## Configuration
- `DISP_BLINK_EN` defined: blink logic (`bcnt`, `phase`, field blanking) is present as described.
- `DISP_BLINK_EN` not defined: no blink counter, `en_count` is ignored, and all six slots are always lit (anti-ghost blanking still applies).

## Structure
- Shared package `disp_pkg`:
  - segment constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF`;
  - field codes `FIELD_HH`=1, `FIELD_MM`=2, `FIELD_SS`=3;
  - `N_SLOTS`=6;
  - slot-index constants.
- Sub-module `bcd_to_7seg`: combinational 4-bit → 7-bit active-low decoder, instantiated once on the muxed digit.

## Test plan
All scenarios use `REFRESH_DIV`=4, `BLANK_CYC`=1, `BLINK_TICKS`=2 unless noted.
- Reset: hold `reset`=0 with clocks running → `an`=8'hFF, `seg`=7'h7F, `dp`=1. Release → first lit slot is `an`=8'b11111110, showing `ss0`.
- Scan: digits 1,2,3,4,5,6 (hh1..ss0) and `en_count`=0 → slots cycle `an[0]`..`an[5]` showing 6,5,4,3,2,1, with `dp`=0 only on `an[2]` and `an[4]`. `an[7:6]` never go low. `an`=8'hFF for 1 cycle at each slot start.
- Invalid BCD: `mm0`=4'hC → slot 2 `seg`=7'b0111111; `mm0`=0 → slot 2 `seg`=7'b1000000.
- Blink: `en_count`=2 → `an[3:2]` stay high for 2 ticks, then low for 2 ticks, alternating; other slots are unaffected. `en_count`=7 → no slot blinks. Rebuilt without `DISP_BLINK_EN`, `en_count`=2 → `an[3:2]` lit every scan.
- Async reset mid-slot at idx 3 with `phase`=0 → outputs reach reset values before the next clk edge; after release, `phase`=1 and `idx`=0.
- Wrap/coincidence: with `BLINK_TICKS`=6, run to the tick at idx 5 → next slot is idx 0 and `phase` has toggled on the same edge.
